// File: rtl/fp_loo_sequencer.sv
// rtl/fp_loo_sequencer.sv - issue/writeback sequencer around the fixed-latency FP convert unit
// Credit-based issue into the unit, tag tracking through its latency, result FIFO toward the CDB.
module fp_loo_sequencer #(
  parameter int FPWID = 52,
  parameter int TAGW  = 5,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_v,
  output logic             req_rdy,
  input  logic [1:0]       req_func,
  input  logic [2:0]       req_rm,
  input  logic [TAGW-1:0]  req_tag,
  input  logic [FPWID-1:0] req_a,
  output logic             fu_ce,
  output logic [1:0]       fu_func,
  output logic [2:0]       fu_rm,
  output logic [FPWID-1:0] fu_a,
  input  logic [FPWID-1:0] fu_o,
  output logic             res_v,
  input  logic             res_rdy,
  output logic [TAGW-1:0]  res_tag,
  output logic [FPWID-1:0] res_o,
  output logic             res_exc,
  input  logic             flush,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = PW + 1;

  logic [1:0]               func_q;
  logic [2:0]               rm_q;
  logic [FPWID-1:0]         a_q;
  logic [LAT-1:0]           v_q, v_d;
  logic [LAT-1:0][TAGW-1:0] tag_q, tag_d;
  logic [LAT-1:0]           exc_q, exc_d;
  logic [PW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]            occ;
  logic [CW-1:0]            inflight;
  logic [TAGW-1:0]          mem_tag_q  [DEPTH];
  logic [FPWID-1:0]         mem_data_q [DEPTH];
  logic [DEPTH-1:0]         mem_exc_q;
  logic                     accept, push, pop;

  assign fu_ce   = 1'b1;
  assign fu_func = func_q;
  assign fu_rm   = rm_q;
  assign fu_a    = a_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(v_q[i]);
  end

  // Queue slots are reserved at issue time, so an exiting stage always finds room.
  assign occ     = wr_q - rd_q;
  assign req_rdy = rst_n & ~flush & ((CW'(occ) + inflight) < CW'(DEPTH));
  assign accept  = req_v & req_rdy;
  assign push    = v_q[LAT-1] & ~flush;
  assign pop     = res_v & res_rdy;
  assign busy    = (inflight != '0) | (occ != '0);

  assign res_v   = occ != '0;
  assign res_tag = res_v ? mem_tag_q[rd_q[AW-1:0]]  : '0;
  assign res_o   = res_v ? mem_data_q[rd_q[AW-1:0]] : '0;
  assign res_exc = res_v & mem_exc_q[rd_q[AW-1:0]];

  always_comb begin
    v_d   = '0;
    tag_d = tag_q;
    exc_d = exc_q;
    v_d[0] = accept;
    if (accept) begin
      tag_d[0] = req_tag;
      exc_d[0] = req_func == 2'd3;
    end
    for (int i = 1; i < LAT; i++) begin
      v_d[i]   = v_q[i-1];
      tag_d[i] = tag_q[i-1];
      exc_d[i] = exc_q[i-1];
    end
    if (flush) v_d = '0;
  end

  always_comb begin
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= '0;
      rm_q   <= '0;
      a_q    <= '0;
      v_q    <= '0;
      tag_q  <= '0;
      exc_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        func_q <= req_func;
        rm_q   <= req_rm;
        a_q    <= req_a;
      end
      v_q   <= v_d;
      tag_q <= tag_d;
      exc_q <= exc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  // Storage needs no reset: the head is masked by res_v whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag_q[wr_q[AW-1:0]]  <= tag_q[LAT-1];
      mem_data_q[wr_q[AW-1:0]] <= exc_q[LAT-1] ? '0 : fu_o;
      mem_exc_q[wr_q[AW-1:0]]  <= exc_q[LAT-1];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && occ == PW'(DEPTH)));

endmodule
